// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags to Dispatch, marks entries done on
// writeback, retires one entry per cycle in program order, and flushes on a mispredicted branch.
// Ports: clk/rst (async active-low); rob_push_i/rob_entry_i in, rob_full_o/rob_alloc_tag_o/
//        rob_count_o out; wb_valid_i/wb_tag_i/wb_mispredict_i in; commit_*_o and flush_o out.
// Latency: a push at cycle N with writeback at N+1 commits at N+2 at the earliest.
// Backpressure: rob_full_o depends on current occupancy only; a push while full is dropped.

package rob_pkg;
    localparam int ROB_XLEN   = 32;
    localparam int ROB_PREG_W = 6;

    typedef struct packed {
        logic [ROB_XLEN-1:0]   pc;
        logic [ROB_PREG_W-1:0] rd_phys;
        logic [ROB_PREG_W-1:0] rd_old;
    } rob_entry_t;
endpackage

module reorder_buffer
    import rob_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = 4,
    parameter int PREG_W = ROB_PREG_W,
    parameter int XLEN   = ROB_XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rob_push_i,
    input  rob_entry_t        rob_entry_i,
    output logic              rob_full_o,
    output logic [TAG_W-1:0]  rob_alloc_tag_o,
    output logic [TAG_W:0]    rob_count_o,
    input  logic              wb_valid_i,
    input  logic [TAG_W-1:0]  wb_tag_i,
    input  logic              wb_mispredict_i,
    output logic              commit_valid_o,
    output logic              commit_has_rd_o,
    output logic [PREG_W-1:0] commit_rd_phys_o,
    output logic [PREG_W-1:0] commit_rd_old_o,
    output logic [XLEN-1:0]   commit_pc_o,
    output logic              flush_o
);

    localparam logic [TAG_W:0] PTR_ONE   = 1;
    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(DEPTH);

    // Pointers carry a wrap bit above the index so full and empty are distinguishable.
    logic [TAG_W:0]   head_q, head_d;
    logic [TAG_W:0]   tail_q, tail_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [DEPTH-1:0] mis_q, mis_d;
    rob_entry_t       entry_q [DEPTH];

    logic [TAG_W-1:0] head_idx;
    logic [TAG_W-1:0] tail_idx;
    logic             push_acc;
    rob_entry_t       head_e;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];
    assign head_e   = entry_q[head_idx];

    assign rob_count_o     = tail_q - head_q;
    assign rob_full_o      = (rob_count_o == DEPTH_CNT);
    assign rob_alloc_tag_o = tail_idx;
    assign push_acc        = rob_push_i && !rob_full_o;

    assign commit_valid_o   = valid_q[head_idx] && done_q[head_idx];
    assign flush_o          = commit_valid_o && mis_q[head_idx];
    assign commit_pc_o      = commit_valid_o ? head_e.pc      : '0;
    assign commit_rd_phys_o = commit_valid_o ? head_e.rd_phys : '0;
    assign commit_rd_old_o  = commit_valid_o ? head_e.rd_old  : '0;
    assign commit_has_rd_o  = commit_valid_o && (head_e.rd_phys != '0);

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        mis_d   = mis_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush_o) begin
            // The branch retires; everything younger is discarded, including any
            // push or writeback arriving this cycle. Empty with head == tail.
            valid_d = '0;
            done_d  = '0;
            mis_d   = '0;
            head_d  = head_q + PTR_ONE;
            tail_d  = head_q + PTR_ONE;
        end else begin
            if (push_acc) begin
                valid_d[tail_idx] = 1'b1;
                done_d[tail_idx]  = 1'b0;
                mis_d[tail_idx]   = 1'b0;
                tail_d            = tail_q + PTR_ONE;
            end
            // The tail slot is never valid while a push is accepted, so a writeback
            // can never collide with the entry being allocated.
            if (wb_valid_i && valid_q[wb_tag_i]) begin
                done_d[wb_tag_i] = 1'b1;
                mis_d[wb_tag_i]  = wb_mispredict_i;
            end
            if (commit_valid_o) begin
                valid_d[head_idx] = 1'b0;
                head_d            = head_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
            mis_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
        end
    end

    // Payload needs no reset: it is only observed through a valid entry.
    always_ff @(posedge clk) begin
        if (push_acc && !flush_o) begin
            entry_q[tail_idx] <= rob_entry_i;
        end
    end

endmodule
